cascade_bcd_counter: RTL and testbench

CASCADE_BCD_COUNTER -- requirements
Module: cascade_bcd_counter

---
 rtl/cascade_bcd_counter.sv | 121 ++++++++++++
 tb/tb_cascade_bcd_counter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cascade_bcd_counter.sv
// Cascaded BCD up/down counter with run/stop control and a wrap or one-shot rollover.
// Digits are packed 4 bits each; digit 0 is the least significant.

module cascade_bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic [3:0] i_digit,
    input  logic       i_up,
    input  logic       i_en,
    output logic       o_carry,
    output logic [3:0] o_next
);
    logic [3:0] w_adv;

    // Out-of-range digits fold back into [0, MAX] on the next step
    always_comb begin
        o_carry = i_up ? (i_digit == MAX) : (i_digit == 4'd0);
        if (i_up)
            w_adv = (i_digit >= MAX) ? 4'd0 : i_digit + 4'd1;
        else
            w_adv = (i_digit == 4'd0 || i_digit > MAX) ? MAX : i_digit - 4'd1;
        o_next = i_en ? w_adv : i_digit;
    end
endmodule

module cascade_bcd_counter #(
    parameter int                      N_DIGITS  = 4,
    parameter logic [4*N_DIGITS-1:0]   MAX_VALS  = 16'h5959,
    parameter logic [4*N_DIGITS-1:0]   RESET_VAL = '0,
    parameter bit                      WRAP      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  up_dn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
    output logic [4*N_DIGITS-1:0] count,
    output logic [N_DIGITS-1:0]   carry,
    output logic                  tc,
    output logic                  done,
    output logic                  running,
    output logic                  expired
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  r_state;
    logic [4*N_DIGITS-1:0]   r_count;
    logic                    r_done, r_running, r_expired;
    logic [N_DIGITS-1:0]     w_en;
    logic [4*N_DIGITS-1:0]   w_next;

    // A digit advances only when every lower digit sits at its terminal value
    assign w_en[0] = 1'b1;
    for (genvar i = 1; i < N_DIGITS; i++) begin : g_en
        assign w_en[i] = w_en[i-1] & carry[i-1];
    end

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
        cascade_bcd_digit #(.MAX(MAX_VALS[4*i +: 4])) u_dig (
            .i_digit (r_count[4*i +: 4]),
            .i_up    (up_dn),
            .i_en    (w_en[i]),
            .o_carry (carry[i]),
            .o_next  (w_next[4*i +: 4])
        );
    end

    assign tc      = &carry;
    assign count   = r_count;
    assign done    = r_done;
    assign running = r_running;
    assign expired = r_expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= RESET_VAL;
            r_state   <= IDLE;
            r_done    <= 1'b0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_count   <= load_val;
                r_state   <= IDLE;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (start && !stop) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                    RUN: if (stop) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end else if (tick) begin
                        r_done <= tc;
                        // One-shot mode freezes the terminal count instead of wrapping
                        if (tc && !WRAP) begin
                            r_state   <= DONE;
                            r_running <= 1'b0;
                            r_expired <= 1'b1;
                        end else begin
                            r_count <= w_next;
                        end
                    end
                    DONE: ;
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                        r_expired <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cascade_bcd_counter.sv
// Directed bench: a wrapping and a one-shot counter driven from shared inputs.
module tb_cascade_bcd_counter;
    logic        clk = 1'b0;
    logic        reset, tick, up_dn, start, stop, load;
    logic [15:0] load_val;
    logic [15:0] w_count, o_count;
    logic [3:0]  w_carry, o_carry;
    logic        w_tc, w_done, w_running, w_expired;
    logic        o_tc, o_done, o_running, o_expired;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    cascade_bcd_counter #(.WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .tick(tick), .up_dn(up_dn), .start(start),
        .stop(stop), .load(load), .load_val(load_val), .count(w_count),
        .carry(w_carry), .tc(w_tc), .done(w_done), .running(w_running),
        .expired(w_expired)
    );

    cascade_bcd_counter #(.WRAP(1'b0)) u_once (
        .clk(clk), .reset(reset), .tick(tick), .up_dn(up_dn), .start(start),
        .stop(stop), .load(load), .load_val(load_val), .count(o_count),
        .carry(o_carry), .tc(o_tc), .done(o_done), .running(o_running),
        .expired(o_expired)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; tick = 0; up_dn = 1; start = 0; stop = 0; load = 0; load_val = '0;
        #1;
        chk("rst_count", w_count, 16'h0000);
        chk("rst_running", {15'd0, w_running}, 16'd0);
        chk("rst_expired", {15'd0, w_expired}, 16'd0);
        chk("rst_done", {15'd0, w_done}, 16'd0);
        step(); step();
        reset = 1'b0;
        step();

        // up carry across two digits
        load = 1; load_val = 16'h0059; step(); load = 0;
        chk("ld_count", w_count, 16'h0059);
        chk("ld_running", {15'd0, w_running}, 16'd0);
        chk("up_carry", {12'd0, w_carry}, 16'h0003);
        chk("up_tc", {15'd0, w_tc}, 16'd0);
        tick = 1; step(); tick = 0;
        chk("idle_tick", w_count, 16'h0059);
        start = 1; step(); start = 0;
        chk("start_run", {15'd0, w_running}, 16'd1);
        tick = 1; step(); tick = 0;
        chk("up_step", w_count, 16'h0100);
        chk("up_done", {15'd0, w_done}, 16'd0);

        // down borrow; carry follows up_dn combinationally
        up_dn = 0; #1;
        chk("dn_carry", {12'd0, w_carry}, 16'h000B);
        tick = 1; step(); tick = 0;
        chk("dn_step", w_count, 16'h0059);

        // load wins over tick
        load = 1; load_val = 16'h1234; tick = 1; step(); load = 0; tick = 0;
        chk("ld_tick_count", w_count, 16'h1234);
        chk("ld_tick_idle", {15'd0, w_running}, 16'd0);

        // start+stop together stays idle; stop in RUN suppresses tick
        start = 1; stop = 1; step(); start = 0; stop = 0;
        chk("start_stop", {15'd0, w_running}, 16'd0);
        start = 1; step(); start = 0;
        stop = 1; tick = 1; step(); stop = 0; tick = 0;
        chk("stop_tick_count", w_count, 16'h1234);
        chk("stop_idle", {15'd0, w_running}, 16'd0);

        // async reset mid-run
        start = 1; step(); start = 0;
        tick = 1; step(); tick = 0;
        chk("run_dn", w_count, 16'h1233);
        reset = 1; #1;
        chk("arst_count", w_count, 16'h0000);
        chk("arst_running", {15'd0, w_running}, 16'd0);
        chk("arst_done", {15'd0, w_done}, 16'd0);
        step(); reset = 0; step();
        tick = 1; step(); tick = 0;
        chk("post_rst_idle", w_count, 16'h0000);

        // WRAP=1 up rollover; one-shot instance expires at the same point
        up_dn = 1; load = 1; load_val = 16'h5959; step(); load = 0;
        chk("max_tc", {15'd0, w_tc}, 16'd1);
        start = 1; step(); start = 0;
        tick = 1; step(); tick = 0;
        chk("wrap_count", w_count, 16'h0000);
        chk("wrap_done", {15'd0, w_done}, 16'd1);
        chk("wrap_running", {15'd0, w_running}, 16'd1);
        chk("once_hold", o_count, 16'h5959);
        chk("once_expired", {15'd0, o_expired}, 16'd1);
        step();
        chk("wrap_done_clr", {15'd0, w_done}, 16'd0);

        // WRAP=1 down rollover from zero
        up_dn = 0; tick = 1; step(); tick = 0;
        chk("dn_wrap_count", w_count, 16'h5959);
        chk("dn_wrap_done", {15'd0, w_done}, 16'd1);

        // WRAP=0 expiry
        load = 1; load_val = 16'h0001; step(); load = 0;
        start = 1; step(); start = 0;
        tick = 1; step();
        chk("once_zero", o_count, 16'h0000);
        chk("once_tc", {15'd0, o_tc}, 16'd1);
        chk("once_nodone", {15'd0, o_done}, 16'd0);
        step(); tick = 0;
        chk("once_frozen", o_count, 16'h0000);
        chk("once_done", {15'd0, o_done}, 16'd1);
        chk("once_exp", {15'd0, o_expired}, 16'd1);
        chk("once_notrun", {15'd0, o_running}, 16'd0);
        tick = 1; step(); tick = 0;
        chk("once_done_clr", {15'd0, o_done}, 16'd0);
        chk("once_tick_ign", o_count, 16'h0000);
        start = 1; step(); start = 0;
        chk("once_start_ign", {15'd0, o_running}, 16'd0);
        chk("once_still_exp", {15'd0, o_expired}, 16'd1);
        load = 1; load_val = 16'h0002; step(); load = 0;
        chk("once_ld_clr", {15'd0, o_expired}, 16'd0);
        chk("once_ld_val", o_count, 16'h0002);

        // out-of-range loads
        up_dn = 1; load = 1; load_val = 16'h00A9; step(); load = 0;
        start = 1; step(); start = 0;
        tick = 1; step(); tick = 0;
        chk("oor_up", w_count, 16'h0000);
        up_dn = 0; load = 1; load_val = 16'h00A0; step(); load = 0;
        start = 1; step(); start = 0;
        tick = 1; step(); tick = 0;
        chk("oor_dn", w_count, 16'h0059);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
